// File: rtl/audio_i2s_stream_tx.sv
// Stereo I2S / left-justified DAC serializer with a frame FIFO, mute and sticky underrun flag.
// All serial outputs are registered and change only on the BCK falling edge.
module audio_i2s_stream_tx #(
   parameter int DATA_W     = 16,
   parameter int SLOT_W     = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int BCLK_DIV   = 6
) (
   input  logic                          iCLK,
   input  logic                          iRST,
   input  logic [2*DATA_W-1:0]           iDATA,
   input  logic                          iVALID,
   output logic                          oREADY,
   output logic [$clog2(FIFO_DEPTH):0]   oLEVEL,
   input  logic                          iMODE,
   input  logic                          iMUTE,
   input  logic                          iCLR_UNDR,
   output logic                          oUNDERRUN,
   output logic                          oAUD_BCK,
   output logic                          oAUD_LRCK,
   output logic                          oAUD_DATA
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int FRAME_W = 2 * SLOT_W;
   localparam int B_W     = $clog2(FRAME_W);

   logic [2*DATA_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;

   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic                 bck_q, bck_d;
   logic [B_W-1:0]       slot_q, slot_d;
   logic [FRAME_W-1:0]   shreg_q, shreg_d;
   logic                 mode_q, mode_d;
   logic                 lrck_q, lrck_d;
   logic                 data_q, data_d;
   logic                 undr_q, undr_d;

   logic                 div_wrap, fall_ev, frame_start;
   logic                 fifo_empty, fifo_full, push, pop;
   logic [2*DATA_W-1:0]  head;
   logic [SLOT_W-1:0]    left_pad, right_pad;
   logic [FRAME_W-1:0]   shift_src;
   logic [B_W-1:0]       slot_nxt;
   logic                 mode_eff;

   assign div_wrap    = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
   assign fall_ev     = div_wrap & bck_q;
   assign frame_start = fall_ev & (slot_q == '0);

   assign fifo_empty  = (level_q == '0);
   assign fifo_full   = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop         = frame_start & ~fifo_empty;
   // A full FIFO can still take a write on the cycle its head is popped.
   assign push        = iVALID & (~fifo_full | pop);

   assign head      = mem_q[rd_ptr_q];
   assign left_pad  = SLOT_W'(head[2*DATA_W-1:DATA_W]) << (SLOT_W - DATA_W);
   assign right_pad = SLOT_W'(head[DATA_W-1:0]) << (SLOT_W - DATA_W);
   assign shift_src = frame_start ? (pop ? {left_pad, right_pad} : '0) : shreg_q;
   assign mode_eff  = frame_start ? iMODE : mode_q;
   assign slot_nxt  = (slot_q == B_W'(FRAME_W - 1)) ? '0 : slot_q + B_W'(1);

   always_comb begin
      wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d   = level_q;
      if (push && !pop)
         level_d = level_q + LVL_W'(1);
      else if (pop && !push)
         level_d = level_q - LVL_W'(1);

      div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
      bck_d     = div_wrap ? ~bck_q : bck_q;

      slot_d    = slot_q;
      shreg_d   = shreg_q;
      mode_d    = mode_q;
      lrck_d    = lrck_q;
      data_d    = data_q;
      if (fall_ev) begin
         slot_d  = slot_nxt;
         shreg_d = shift_src << 1;
         mode_d  = mode_eff;
         data_d  = ~iMUTE & shift_src[FRAME_W-1];
         // I2S flips LRCK one slot early so the MSB lands one BCK after the edge.
         lrck_d  = mode_eff ? (slot_nxt >= B_W'(SLOT_W)) : (slot_q >= B_W'(SLOT_W));
      end

      undr_d = (frame_start & fifo_empty) | (undr_q & ~iCLR_UNDR);
   end

   always_ff @(posedge iCLK) begin
      if (push)
         mem_q[wr_ptr_q] <= iDATA;
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         div_cnt_q <= '0;
         bck_q     <= 1'b0;
         slot_q    <= '0;
         shreg_q   <= '0;
         mode_q    <= 1'b0;
         lrck_q    <= 1'b0;
         data_q    <= 1'b0;
         undr_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         div_cnt_q <= div_cnt_d;
         bck_q     <= bck_d;
         slot_q    <= slot_d;
         shreg_q   <= shreg_d;
         mode_q    <= mode_d;
         lrck_q    <= lrck_d;
         data_q    <= data_d;
         undr_q    <= undr_d;
      end
   end

   assign oREADY    = ~fifo_full;
   assign oLEVEL    = level_q;
   assign oUNDERRUN = undr_q;
   assign oAUD_BCK  = bck_q;
   assign oAUD_LRCK = lrck_q;
   assign oAUD_DATA = data_q;

endmodule

// File: tb/tb_audio_i2s_stream_tx.sv
// Directed bench for audio_i2s_stream_tx: frame serialization in LJ/I2S, FIFO fill, underrun, mute, reset.
module tb_audio_i2s_stream_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] idata = '0;
   logic        ivalid = 1'b0;
   logic        mode = 1'b0, mute = 1'b0, clr = 1'b0;
   logic        ready, undr, bck, lrck, sdata;
   logic [2:0]  level;

   logic [23:0] idata12 = '0;
   logic        ivalid12 = 1'b0;
   logic        ready12, undr12, bck12, lrck12, sdata12;
   logic [2:0]  level12;

   int checks = 0;
   int errors = 0;
   int nfall  = 0;
   logic bck_prev = 1'b0;
   logic [31:0] wq[$];
   logic [31:0] cd, cl, cd12;

   always #5 clk = ~clk;

   audio_i2s_stream_tx #(.DATA_W(16), .SLOT_W(16), .FIFO_DEPTH(4), .BCLK_DIV(2)) dut (
      .iCLK(clk), .iRST(rst), .iDATA(idata), .iVALID(ivalid), .oREADY(ready), .oLEVEL(level),
      .iMODE(mode), .iMUTE(mute), .iCLR_UNDR(clr), .oUNDERRUN(undr),
      .oAUD_BCK(bck), .oAUD_LRCK(lrck), .oAUD_DATA(sdata));

   audio_i2s_stream_tx #(.DATA_W(12), .SLOT_W(16), .FIFO_DEPTH(4), .BCLK_DIV(2)) dut12 (
      .iCLK(clk), .iRST(rst), .iDATA(idata12), .iVALID(ivalid12), .oREADY(ready12), .oLEVEL(level12),
      .iMODE(mode), .iMUTE(mute), .iCLR_UNDR(clr), .oUNDERRUN(undr12),
      .oAUD_BCK(bck12), .oAUD_LRCK(lrck12), .oAUD_DATA(sdata12));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample after the edge, count BCK falls, feed the next queued write.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bck_prev && !bck) nfall++;
      bck_prev = bck;
      if (wq.size() > 0) begin
         idata  = wq.pop_front();
         ivalid = 1'b1;
      end else begin
         ivalid = 1'b0;
      end
   endtask

   task automatic wait_fall();
      int n0;
      n0 = nfall;
      for (int i = 0; i < 20 && nfall == n0; i++) tick();
      if (nfall == n0) begin
         errors++;
         $error("FAIL fall_timeout observed none expected BCK fall");
      end
   endtask

   // Align to the end of a frame (last fall was slot 31), then grab 32 slots.
   task automatic capture(output logic [31:0] d, output logic [31:0] l, output logic [31:0] d12);
      for (int i = 0; i < 300 && (nfall % 32) != 0; i++) tick();
      d = '0; l = '0; d12 = '0;
      for (int i = 0; i < 32; i++) begin
         wait_fall();
         d[31-i]   = sdata;
         l[31-i]   = lrck;
         d12[31-i] = sdata12;
      end
   endtask

   initial begin
      // power-on reset
      tick(); tick();
      chk("por_bck", {31'd0, bck}, 32'd0);
      chk("por_lrck", {31'd0, lrck}, 32'd0);
      chk("por_data", {31'd0, sdata}, 32'd0);
      chk("por_level", {29'd0, level}, 32'd0);
      chk("por_ready", {31'd0, ready}, 32'd1);
      chk("por_undr", {31'd0, undr}, 32'd0);

      // release, first BCK rise after 2 cycles; LJ frame queued before first fall
      rst = 1'b0; nfall = 0; bck_prev = 1'b0;
      mode = 1'b0;
      wq.push_back(32'hA5A5_0F0F);
      tick();
      chk("rise_c1", {31'd0, bck}, 32'd0);
      tick();
      chk("rise_c2", {31'd0, bck}, 32'd1);

      capture(cd, cl, cd12);
      chk("lj_data", cd, 32'hA5A5_0F0F);
      chk("lj_lrck", cl, 32'h0000_FFFF);
      chk("lj_undr", {31'd0, undr}, 32'd0);

      // I2S, same frame
      mode = 1'b1;
      wq.push_back(32'hA5A5_0F0F);
      capture(cd, cl, cd12);
      chk("i2s_data", cd, 32'hA5A5_0F0F);
      chk("i2s_lrck", cl, 32'h0001_FFFE);

      // underrun frame
      mode = 1'b0;
      capture(cd, cl, cd12);
      chk("undr_data", cd, 32'h0);
      chk("undr_lrck", cl, 32'h0000_FFFF);
      chk("undr_set", {31'd0, undr}, 32'd1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("undr_clr", {31'd0, undr}, 32'd0);
      tick(); tick();
      clr = 1'b1; tick(); clr = 1'b0;
      chk("undr_set_wins", {31'd0, undr}, 32'd1);
      chk("undr_frame_start", nfall % 32, 32'd1);

      // fill: 5 writes, no pops until next frame start
      wq.push_back(32'h1234_5678);
      wq.push_back(32'h9ABC_DEF0);
      wq.push_back(32'h0F1E_2D3C);
      wq.push_back(32'hC3C3_5A5A);
      wq.push_back(32'hDEAD_BEEF);
      tick(); tick(); tick(); tick(); tick();
      chk("full_level", {29'd0, level}, 32'd4);
      chk("full_ready", {31'd0, ready}, 32'd0);
      tick(); tick();
      chk("full_drop_level", {29'd0, level}, 32'd4);
      capture(cd, cl, cd12);
      chk("fifo_f1", cd, 32'h1234_5678);
      capture(cd, cl, cd12);
      chk("fifo_f2", cd, 32'h9ABC_DEF0);
      capture(cd, cl, cd12);
      chk("fifo_f3", cd, 32'h0F1E_2D3C);
      capture(cd, cl, cd12);
      chk("fifo_f4", cd, 32'hC3C3_5A5A);
      chk("fifo_drained", {29'd0, level}, 32'd0);

      // mute
      mute = 1'b1;
      wq.push_back(32'hFFFF_FFFF);
      tick(); tick();
      chk("mute_level_pre", {29'd0, level}, 32'd1);
      capture(cd, cl, cd12);
      chk("mute_data", cd, 32'h0);
      chk("mute_level_post", {29'd0, level}, 32'd0);

      // mid-frame reset
      mute = 1'b0;
      wq.push_back(32'hFFFF_FFFF);
      wq.push_back(32'hFFFF_FFFF);
      for (int i = 0; i < 300 && (nfall % 32) != 0; i++) tick();
      for (int i = 0; i < 17; i++) wait_fall();
      tick(); tick();
      chk("mid_pre_data", {31'd0, sdata}, 32'd1);
      chk("mid_pre_lrck", {31'd0, lrck}, 32'd1);
      chk("mid_pre_bck", {31'd0, bck}, 32'd1);
      chk("mid_pre_level", {29'd0, level}, 32'd1);
      chk("mid_pre_undr", {31'd0, undr}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_bck", {31'd0, bck}, 32'd0);
      chk("mid_lrck", {31'd0, lrck}, 32'd0);
      chk("mid_data", {31'd0, sdata}, 32'd0);
      chk("mid_level", {29'd0, level}, 32'd0);
      chk("mid_ready", {31'd0, ready}, 32'd1);
      chk("mid_undr", {31'd0, undr}, 32'd0);
      tick();
      rst = 1'b0; nfall = 0; bck_prev = 1'b0;

      // 12-bit samples in 16-bit slots
      idata12  = {12'hFFF, 12'h800};
      ivalid12 = 1'b1;
      tick();
      ivalid12 = 1'b0;
      chk("rel_rise_c1", {31'd0, bck}, 32'd0);
      tick();
      chk("rel_rise_c2", {31'd0, bck}, 32'd1);
      capture(cd, cl, cd12);
      chk("w12_data", cd12, 32'hFFF0_8000);
      chk("w12_main_empty", cd, 32'h0);
      chk("w12_main_undr", {31'd0, undr}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
